// File: rtl/top.sv
// top: sums five 4-word RAM groups into word 5k+4, then writes the grand total into word 31
module top #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int N_GROUPS = 5,
  parameter int GROUP_LEN = 4,
  parameter int TOTAL_ADDR = 31
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);
  typedef enum logic [2:0] {RD, CAP, WR, P1, TW, P2, HALT} state_t;
  state_t state, nxt;
  logic [2:0] k, nk;
  logic [1:0] i, ni;
  logic [DATA_W-1:0] acc, nacc, total, ntot, sum, din_n;
  logic [ADDR_W-1:0] base, addr_n;
  logic cap_q, re_n, we_n, rdy_n;
  assign base = ADDR_W'(k) * ADDR_W'(N_GROUPS);
  assign sum = cap_q ? acc + mem_data_out : acc;
  always_comb begin
    nxt = state;
    nk = k;
    ni = i;
    nacc = acc;
    ntot = total;
    addr_n = '0;
    din_n = '0;
    re_n = 1'b0;
    we_n = 1'b0;
    rdy_n = 1'b0;
    case (state)
      RD: begin
        addr_n = base + ADDR_W'(i);
        re_n = 1'b1;
        nacc = sum;
        nxt = CAP;
      end
      CAP: begin
        ni = (i == 2'(GROUP_LEN - 1)) ? i : i + 2'd1;
        nxt = (i == 2'(GROUP_LEN - 1)) ? WR : RD;
      end
      WR: begin
        addr_n = base + ADDR_W'(GROUP_LEN);
        din_n = sum;
        we_n = 1'b1;
        ntot = total + sum;
        nacc = '0;
        ni = '0;
        nk = (k == 3'(N_GROUPS - 1)) ? k : k + 3'd1;
        nxt = (k == 3'(N_GROUPS - 1)) ? P1 : RD;
      end
      P1: begin
        rdy_n = 1'b1;
        nxt = TW;
      end
      TW: begin
        addr_n = ADDR_W'(TOTAL_ADDR);
        din_n = total;
        we_n = 1'b1;
        nxt = P2;
      end
      P2: begin
        rdy_n = 1'b1;
        nxt = HALT;
      end
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RD;
      k <= '0;
      i <= '0;
      acc <= '0;
      total <= '0;
      cap_q <= 1'b0;
      ready <= 1'b0;
      mem_address <= '0;
      mem_read_enable <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_data_in <= '0;
    end else begin
      state <= nxt;
      k <= nk;
      i <= ni;
      acc <= nacc;
      total <= ntot;
      cap_q <= state == CAP;
      ready <= rdy_n;
      mem_address <= addr_n;
      mem_read_enable <= re_n;
      mem_write_enable <= we_n;
      mem_data_in <= din_n;
    end
  end
endmodule

// File: tb/tb_top.sv
// tb_top: directed scenarios against a behavioural 1-cycle-latency RAM
module tb_top;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready, re, we;
  logic [4:0] addr;
  logic [15:0] din, dout;
  logic [15:0] mem [32];
  logic ld_en = 1'b0;
  logic [4:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic rd_valid = 1'b0;
  logic [15:0] rd_data = '0;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  top dut (
    .clk(clk),
    .reset(reset),
    .ready(ready),
    .mem_address(addr),
    .mem_read_enable(re),
    .mem_write_enable(we),
    .mem_data_in(din),
    .mem_data_out(dout)
  );
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (we) mem[addr] <= din;
    rd_valid <= re;
    if (re) rd_data <= mem[addr];
  end
  assign dout = rd_valid ? rd_data : 16'hDEAD;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("rw_excl", 32'(re & we), 0);
    if (re) chk("rd_addr", 32'(addr >= 5'd24 || addr % 5 == 4), 0);
  endtask
  task automatic load(input int mode);
    reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      ld_en = 1'b1;
      ld_addr = 5'(a);
      ld_data = mode == 0 ? 16'(a) : mode == 1 ? (a < 4 ? 16'hFFFF : 16'(a)) : 16'h0;
      step();
    end
    ld_en = 1'b0;
  endtask
  task automatic run(input logic [15:0] e4, e9, e14, e19, e24, e31);
    int p1, p2, np;
    reset = 1'b1;
    step();
    step();
    chk("rst_out", 32'({ready, re, we, addr, din}), 0);
    reset = 1'b0;
    cyc = 0;
    p1 = 0;
    p2 = 0;
    np = 0;
    repeat (60) begin
      step();
      if (p2 != 0) chk("halt_idle", 32'({ready, re, we}), 0);
      if (ready) begin
        np++;
        if (np == 1) p1 = cyc;
        else if (np == 2) p2 = cyc;
      end
    end
    chk("ready1_cyc", 32'(p1), 46);
    chk("ready2_cyc", 32'(p2), 48);
    chk("ready_cnt", 32'(np), 2);
    chk("ram4", 32'(mem[4]), 32'(e4));
    chk("ram9", 32'(mem[9]), 32'(e9));
    chk("ram14", 32'(mem[14]), 32'(e14));
    chk("ram19", 32'(mem[19]), 32'(e19));
    chk("ram24", 32'(mem[24]), 32'(e24));
    chk("ram31", 32'(mem[31]), 32'(e31));
  endtask
  initial begin
    load(0);
    run(16'd6, 16'd26, 16'd46, 16'd66, 16'd86, 16'd230);
    load(1);
    run(16'hFFFC, 16'd26, 16'd46, 16'd66, 16'd86, 16'd220);
    load(0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) step();
    reset = 1'b1;
    step();
    chk("mid_rst_out", 32'({ready, re, we, addr, din}), 0);
    run(16'd6, 16'd26, 16'd46, 16'd66, 16'd86, 16'd230);
    load(2);
    run(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
